dac_seq: RTL and testbench

Parametrised two-phase waveform sequencer for the DAC output path. It steps through a programmable "up" table and then a "down" table of DW-bit codes, advancing at an internally divided rate. Each phase has a runtime-selectable length. It supports one-shot and continuous modes and drives a programmable idle code when not running. It sits between the register/control logic and the DAC pins, and replaces fixed-length, fixed-width sequencers that had no reset and no completion status.

---
 rtl/dac_seq_if.sv | 34 +++
 rtl/dac_seq.sv | 153 +++++++++++++++
 tb/tb_dac_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dac_seq_if.sv
// Control and DAC-side signal bundle for dac_seq. The master side is the
// register/control logic; the slave side is the sequencer itself.
interface dac_seq_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int DIVW  = 16
);
  localparam int IW = $clog2(DEPTH);

  logic                  en;
  logic                  start;
  logic                  mode;
  logic [DIVW-1:0]       divider;
  logic [DEPTH*DW-1:0]   up_tbl;
  logic [DEPTH*DW-1:0]   down_tbl;
  logic [IW:0]           up_len;
  logic [IW:0]           down_len;
  logic [DW-1:0]         idle_val;
  logic [DW-1:0]         out;
  logic                  phase;
  logic                  busy;
  logic                  step;
  logic                  done;

  modport master (
    output en, start, mode, divider, up_tbl, down_tbl, up_len, down_len, idle_val,
    input  out, phase, busy, step, done
  );

  modport slave (
    input  en, start, mode, divider, up_tbl, down_tbl, up_len, down_len, idle_val,
    output out, phase, busy, step, done
  );
endinterface

// File: rtl/dac_seq.sv
// Two-phase (up table, then down table) DAC waveform sequencer with a
// divided sample rate, one-shot/continuous modes and a done pulse.
module dac_seq #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int DIVW  = 16
) (
  input  logic      clk,
  input  logic      rst,
  dac_seq_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0]     LEN_MAX = (IW+1)'(DEPTH);
  localparam logic [IW:0]     LEN_ONE = (IW+1)'(1);
  localparam logic [IW-1:0]   IDX_ONE = IW'(1);
  localparam logic [DIVW-1:0] DIV_ONE = DIVW'(1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DIVW-1:0] divcnt_q, divcnt_d;
  logic [DIVW-1:0] div_l_q, div_l_d;
  logic [IW:0]     up_len_l_q, up_len_l_d;
  logic [IW:0]     dn_len_l_q, dn_len_l_d;
  logic            mode_l_q, mode_l_d;
  logic [DW-1:0]   out_q, out_d;
  logic            step_q, step_d;
  logic            done_q, done_d;

  logic [DW-1:0]   up_a [DEPTH];
  logic [DW-1:0]   dn_a [DEPTH];
  logic [IW:0]     up_c, dn_c;
  logic            tick, launch, eos, up_last, dn_last;

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign up_a[i] = bus.up_tbl[i*DW +: DW];
    assign dn_a[i] = bus.down_tbl[i*DW +: DW];
  end

  // Clamping here keeps idx strictly below DEPTH, so table reads never go out of range.
  assign up_c    = (bus.up_len   > LEN_MAX) ? LEN_MAX : bus.up_len;
  assign dn_c    = (bus.down_len > LEN_MAX) ? LEN_MAX : bus.down_len;
  assign tick    = (divcnt_q == div_l_q);
  assign up_last = ({1'b0, idx_q} + LEN_ONE) >= up_len_l_q;
  assign dn_last = ({1'b0, idx_q} + LEN_ONE) >= dn_len_l_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    divcnt_d   = divcnt_q;
    div_l_d    = div_l_q;
    up_len_l_d = up_len_l_q;
    dn_len_l_d = dn_len_l_q;
    mode_l_d   = mode_l_q;
    step_d     = 1'b0;
    done_d     = 1'b0;
    launch     = 1'b0;
    eos        = 1'b0;

    if (!bus.en) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      divcnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: launch = bus.start && ((up_c != '0) || (dn_c != '0));
        S_UP: begin
          if (!tick) divcnt_d = divcnt_q + DIV_ONE;
          else begin
            divcnt_d = '0;
            if (!up_last) begin
              idx_d  = idx_q + IDX_ONE;
              step_d = 1'b1;
            end else if (dn_len_l_q != '0) begin
              state_d = S_DOWN;
              idx_d   = '0;
              step_d  = 1'b1;
            end else eos = 1'b1;
          end
        end
        S_DOWN: begin
          if (!tick) divcnt_d = divcnt_q + DIV_ONE;
          else begin
            divcnt_d = '0;
            if (!dn_last) begin
              idx_d  = idx_q + IDX_ONE;
              step_d = 1'b1;
            end else eos = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (eos) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        idx_d   = '0;
        // Continuous restart re-reads live config, so it obeys the same zero-length rule as start.
        launch  = mode_l_q && ((up_c != '0) || (dn_c != '0));
      end

      if (launch) begin
        div_l_d    = bus.divider;
        up_len_l_d = up_c;
        dn_len_l_d = dn_c;
        mode_l_d   = bus.mode;
        state_d    = (up_c != '0) ? S_UP : S_DOWN;
        idx_d      = '0;
        divcnt_d   = '0;
        step_d     = 1'b1;
      end
    end

    unique case (state_d)
      S_UP:    out_d = up_a[idx_d];
      S_DOWN:  out_d = dn_a[idx_d];
      default: out_d = bus.idle_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      divcnt_q   <= '0;
      div_l_q    <= '0;
      up_len_l_q <= '0;
      dn_len_l_q <= '0;
      mode_l_q   <= 1'b0;
      out_q      <= '0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      divcnt_q   <= divcnt_d;
      div_l_q    <= div_l_d;
      up_len_l_q <= up_len_l_d;
      dn_len_l_q <= dn_len_l_d;
      mode_l_q   <= mode_l_d;
      out_q      <= out_d;
      step_q     <= step_d;
      done_q     <= done_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.phase = (state_q == S_DOWN);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.step  = step_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_dac_seq.sv
// Scoreboard bench for dac_seq: each start pushes the expected samples (code,
// phase, cycle) and done cycles; the per-cycle monitor pops and compares.
module tb_dac_seq;
  localparam int DW = 8, DEPTH = 16, DIVW = 16;

  typedef struct { int code; int ph; int cyc; } samp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_seq_if #(.DW(DW), .DEPTH(DEPTH), .DIVW(DIVW)) bus ();
  dac_seq #(.DW(DW), .DEPTH(DEPTH), .DIVW(DIVW)) dut (.clk(clk), .rst(rst), .bus(bus));

  samp_t sb[$];
  int    done_q[$];
  int    checks = 0, failures = 0, cyc = 0;
  int    up_v[DEPTH], dn_v[DEPTH];
  int    ul, dl, dv;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d", tag, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    samp_t s;
    @(posedge clk); #1; cyc++;
    if (bus.step) begin
      chk("sb_avail", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        s = sb.pop_front();
        chk("code", int'(bus.out), s.code);
        chk("phase", int'(bus.phase), s.ph);
        chk("step_cyc", cyc, s.cyc);
        chk("busy_run", int'(bus.busy), 1);
      end
    end
    if (bus.done) begin
      chk("done_avail", int'(done_q.size() != 0), 1);
      if (done_q.size() != 0) chk("done_cyc", cyc, done_q.pop_front());
    end
  endtask

  task automatic cfg(input int u, input int d, input int div, input int m);
    ul = u; dl = d; dv = div;
    bus.up_len = u[4:0]; bus.down_len = d[4:0];
    bus.divider = div[DIVW-1:0]; bus.mode = m[0];
    for (int i = 0; i < DEPTH; i++) begin
      bus.up_tbl[i*DW +: DW]   = up_v[i][DW-1:0];
      bus.down_tbl[i*DW +: DW] = dn_v[i][DW-1:0];
    end
  endtask

  task automatic plan(input int c0, input int reps);
    int nu, nd, k;
    nu = (ul > DEPTH) ? DEPTH : ul;
    nd = (dl > DEPTH) ? DEPTH : dl;
    k = 0;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nu; i++) begin sb.push_back('{up_v[i], 0, c0 + 1 + k*(dv+1)}); k++; end
      for (int i = 0; i < nd; i++) begin sb.push_back('{dn_v[i], 1, c0 + 1 + k*(dv+1)}); k++; end
      done_q.push_back(c0 + 1 + k*(dv+1));
    end
  endtask

  task automatic go(input int reps, output int c0);
    c0 = cyc;
    if (reps > 0) plan(c0, reps);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  int c0;

  initial begin
    bus.en = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.divider = '0;
    bus.up_tbl = '0; bus.down_tbl = '0; bus.up_len = '0; bus.down_len = '0;
    bus.idle_val = 8'h80;
    up_v = '{default:0}; dn_v = '{default:0};

    // reset then idle
    tick(); tick();
    chk("rst_out", int'(bus.out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_phase", int'(bus.phase), 0);
    rst = 1'b0;
    tick();
    chk("idle_out", int'(bus.out), 'h80);
    chk("idle_busy", int'(bus.busy), 0);

    // one-shot
    up_v[0] = 'h10; up_v[1] = 'h20; up_v[2] = 'h30;
    dn_v[0] = 'h40; dn_v[1] = 'h50;
    cfg(3, 2, 1, 0);
    go(1, c0);
    run_to(c0 + 11);
    chk("os_end_out", int'(bus.out), 'h80);
    chk("os_end_busy", int'(bus.busy), 0);
    chk("os_sb_left", sb.size(), 0);
    chk("os_done_left", done_q.size(), 0);
    tick();
    chk("os_idle_hold", int'(bus.out), 'h80);

    // continuous, divider 0, then abort with en low
    cfg(3, 2, 0, 1);
    go(2, c0);
    run_to(c0 + 10);
    chk("cont_sb_left", sb.size(), 0);
    chk("cont_busy", int'(bus.busy), 1);
    done_q.delete();
    bus.en = 1'b0;
    tick();
    chk("cont_abort_out", int'(bus.out), 'h80);
    chk("cont_abort_busy", int'(bus.busy), 0);
    bus.en = 1'b1;
    tick();

    // up_len 0 starts in DOWN
    cfg(0, 2, 0, 0);
    go(1, c0);
    run_to(c0 + 3);
    chk("dn_only_out", int'(bus.out), 'h80);
    chk("dn_only_left", sb.size() + done_q.size(), 0);

    // both lengths zero: start ignored
    cfg(0, 0, 0, 0);
    go(0, c0);
    chk("zero_busy", int'(bus.busy), 0);
    tick(); tick();
    chk("zero_out", int'(bus.out), 'h80);

    // abort after second sample (divider 1: second sample shows at c0+3)
    cfg(3, 2, 1, 0);
    go(1, c0);
    run_to(c0 + 3);
    chk("ab_out2", int'(bus.out), 'h20);
    sb.delete(); done_q.delete();
    bus.en = 1'b0;
    tick();
    chk("ab_out", int'(bus.out), 'h80);
    chk("ab_busy", int'(bus.busy), 0);
    bus.en = 1'b1;
    tick();

    // asynchronous reset mid-run
    cfg(3, 2, 1, 0);
    go(1, c0);
    tick(); tick();
    sb.delete(); done_q.delete();
    #1 rst = 1'b1;
    #1;
    chk("arst_out", int'(bus.out), 0);
    chk("arst_busy", int'(bus.busy), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_rel_out", int'(bus.out), 'h80);

    // clamp: up_len 31 -> 16 samples
    for (int i = 0; i < DEPTH; i++) up_v[i] = 3*i + 1;
    cfg(31, 0, 0, 0);
    go(1, c0);
    run_to(c0 + 17);
    chk("clamp_out", int'(bus.out), 'h80);
    chk("clamp_busy", int'(bus.busy), 0);
    chk("clamp_left", sb.size() + done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
